fft_mcu_param: RTL and testbench

- Parametrised main control unit for the FFT datapath; successor to the fixed 32-sample controller.
- Sequences the full N-point transform internally: per butterfly group, load samples, load twiddles, wait for the butterfly, load the output register, then write back.
- Counts beats, groups and stages itself, with valid/ready gating on SRAM traffic.
- Adds inverse-mode latching, abort, busy and stage strobes; drives the addressing unit, SRAM enables, shift registers and the Avalon hand-off.

---
 rtl/fft_mcu_pkg.sv | 23 ++
 rtl/fft_stage_group_cnt.sv | 45 ++++
 rtl/fft_mcu_param.sv | 169 ++++++++++++++++
 tb/tb_fft_mcu_param.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mcu_pkg.sv
// Shared types and constants for the parametrised FFT main control unit.
package fft_mcu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_TW,
        BFLY_WAIT,
        LOAD_OUT,
        SHIFT_OUT,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_IDLE    = 2'b00;
    localparam logic [1:0] ADDR_RD_SAMP = 2'b01;
    localparam logic [1:0] ADDR_RD_TW   = 2'b10;
    localparam logic [1:0] ADDR_WR      = 2'b11;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fft_stage_group_cnt.sv
// Nested group/stage counter: group wraps into the next stage on advance.
// Registered counts, combinational last flags; clear has priority over advance.
module fft_stage_group_cnt #(
    parameter int GROUPS = 2,
    parameter int STAGES = 6,
    parameter int GRP_W  = 1,
    parameter int STG_W  = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             adv,
    output logic [GRP_W-1:0] group_idx,
    output logic [STG_W-1:0] stage_idx,
    output logic             last_group,
    output logic             last_stage
);

    logic [GRP_W-1:0] grp_q;
    logic [STG_W-1:0] stg_q;

    assign last_group = (grp_q == GRP_W'(GROUPS - 1));
    assign last_stage = (stg_q == STG_W'(STAGES - 1));
    assign group_idx  = grp_q;
    assign stage_idx  = stg_q;

    // The final stage keeps its index while the results wait in DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grp_q <= '0;
            stg_q <= '0;
        end else if (clr) begin
            grp_q <= '0;
            stg_q <= '0;
        end else if (adv) begin
            if (last_group) begin
                grp_q <= '0;
                if (!last_stage) stg_q <= stg_q + STG_W'(1);
            end else begin
                grp_q <= grp_q + GRP_W'(1);
            end
        end
    end

endmodule

// File: rtl/fft_mcu_param.sv
// Sequences an N-point FFT: per group load samples, twiddles, wait, load, write back.
// Indices and pulses registered, strobes/enables decoded from state; rd_valid/wr_ready stall beats.
module fft_mcu_param
    import fft_mcu_pkg::*;
#(
    parameter int N_POINTS   = 64,
    parameter int GROUP_SIZE = 32,
    parameter int TW_BEATS   = 16,
    parameter int BFLY_LAT   = 1,
    localparam int STAGES    = $clog2(N_POINTS),
    localparam int GROUPS    = N_POINTS / GROUP_SIZE,
    localparam int STG_W     = max2(1, $clog2(STAGES)),
    localparam int GRP_W     = max2(1, $clog2(GROUPS)),
    localparam int BEAT_W    = max2(1, $clog2(max2(GROUP_SIZE, max2(TW_BEATS, BFLY_LAT))))
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              fft_start,
    input  logic              fft_inverse,
    input  logic              abort,
    input  logic              rd_valid,
    input  logic              wr_ready,
    input  logic              data_sent,
    output logic [1:0]        addr_mode,
    output logic [STG_W-1:0]  stage_idx,
    output logic [GRP_W-1:0]  group_idx,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              read_enable,
    output logic              input_ena,
    output logic              load_enable,
    output logic              output_ena,
    output logic              write_enable,
    output logic              inverse_mode,
    output logic              stage_strobe,
    output logic              busy,
    output logic              fft_done,
    output logic              aborted
);

    localparam logic [BEAT_W-1:0] GS_LAST  = BEAT_W'(GROUP_SIZE - 1);
    localparam logic [BEAT_W-1:0] TW_LAST  = BEAT_W'(TW_BEATS - 1);
    localparam logic [BEAT_W-1:0] LAT_LAST = BEAT_W'(BFLY_LAT - 1);

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic              inv_q;
    logic              abt_q;
    logic              kill;
    logic              grp_adv;
    logic              cnt_clr;
    logic              last_group;
    logic              last_stage;

    assign kill    = abort && (state_q != IDLE);
    assign grp_adv = (state_q == SHIFT_OUT) && wr_ready && (beat_q == GS_LAST) && !abort;
    assign cnt_clr = ((state_q == IDLE) && fft_start) || kill || ((state_q == DONE) && data_sent);

    fft_stage_group_cnt #(
        .GROUPS (GROUPS),
        .STAGES (STAGES),
        .GRP_W  (GRP_W),
        .STG_W  (STG_W)
    ) u_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .clr        (cnt_clr),
        .adv        (grp_adv),
        .group_idx  (group_idx),
        .stage_idx  (stage_idx),
        .last_group (last_group),
        .last_stage (last_stage)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            inv_q   <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            abt_q <= kill;
            if (kill) begin
                state_q <= IDLE;
                beat_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: if (fft_start) begin
                        state_q <= LOAD_A;
                        beat_q  <= '0;
                        inv_q   <= fft_inverse;
                    end
                    LOAD_A: if (rd_valid) begin
                        if (beat_q == GS_LAST) begin
                            state_q <= LOAD_TW;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                    LOAD_TW: if (rd_valid) begin
                        if (beat_q == TW_LAST) begin
                            state_q <= BFLY_WAIT;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                    BFLY_WAIT: begin
                        if (beat_q == LAT_LAST) begin
                            state_q <= LOAD_OUT;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                    LOAD_OUT: state_q <= SHIFT_OUT;
                    SHIFT_OUT: if (wr_ready) begin
                        if (beat_q == GS_LAST) begin
                            beat_q  <= '0;
                            state_q <= (last_group && last_stage) ? DONE : LOAD_A;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                    DONE: if (data_sent) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        addr_mode    = ADDR_IDLE;
        read_enable  = 1'b0;
        input_ena    = 1'b0;
        load_enable  = 1'b0;
        output_ena   = 1'b0;
        write_enable = 1'b0;
        busy         = 1'b1;
        fft_done     = 1'b0;
        case (state_q)
            IDLE: busy = 1'b0;
            LOAD_A: begin
                addr_mode   = ADDR_RD_SAMP;
                read_enable = 1'b1;
                input_ena   = rd_valid;
            end
            LOAD_TW: begin
                addr_mode   = ADDR_RD_TW;
                read_enable = 1'b1;
                input_ena   = rd_valid;
            end
            LOAD_OUT: load_enable = 1'b1;
            SHIFT_OUT: begin
                addr_mode    = ADDR_WR;
                output_ena   = wr_ready;
                write_enable = wr_ready;
            end
            DONE: fft_done = 1'b1;
            default: busy = (state_q != IDLE);
        endcase
    end

    assign stage_strobe = grp_adv && last_group;
    assign beat_idx     = beat_q;
    assign inverse_mode = inv_q;
    assign aborted      = abt_q;

endmodule

// File: tb/tb_fft_mcu_param.sv
// Bench for fft_mcu_param: per-cycle trace table from a nested-loop model, plus hand sequences.
module tb_fft_mcu_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic n_rst;

    // default-parameter instance (sel 0)
    logic st0, iv0, ab0, rv0, wr0, ds0;
    logic [1:0] am0; logic [2:0] stg0; logic [0:0] grp0; logic [4:0] beat0;
    logic re0, ie0, le0, oe0, we0, inv0, ss0, busy0, done0, abt0;
    // small variant instance (sel 1)
    logic st1, iv1, ab1, rv1, wr1, ds1;
    logic [1:0] am1; logic [1:0] stg1; logic [0:0] grp1; logic [3:0] beat1;
    logic re1, ie1, le1, oe1, we1, inv1, ss1, busy1, done1, abt1;

    fft_mcu_param dut (
        .clk(clk), .n_rst(n_rst), .fft_start(st0), .fft_inverse(iv0), .abort(ab0),
        .rd_valid(rv0), .wr_ready(wr0), .data_sent(ds0), .addr_mode(am0),
        .stage_idx(stg0), .group_idx(grp0), .beat_idx(beat0), .read_enable(re0),
        .input_ena(ie0), .load_enable(le0), .output_ena(oe0), .write_enable(we0),
        .inverse_mode(inv0), .stage_strobe(ss0), .busy(busy0), .fft_done(done0),
        .aborted(abt0)
    );

    fft_mcu_param #(.N_POINTS(16), .GROUP_SIZE(16), .TW_BEATS(4), .BFLY_LAT(3)) dut_s (
        .clk(clk), .n_rst(n_rst), .fft_start(st1), .fft_inverse(iv1), .abort(ab1),
        .rd_valid(rv1), .wr_ready(wr1), .data_sent(ds1), .addr_mode(am1),
        .stage_idx(stg1), .group_idx(grp1), .beat_idx(beat1), .read_enable(re1),
        .input_ena(ie1), .load_enable(le1), .output_ena(oe1), .write_enable(we1),
        .inverse_mode(inv1), .stage_strobe(ss1), .busy(busy1), .fft_done(done1),
        .aborted(abt1)
    );

    typedef struct packed {
        logic [1:0] am;
        logic [7:0] beat;
        logic [7:0] grp;
        logic [7:0] stg;
        logic re, ie, le, oe, we, ss, busy, done, inv, abt;
    } obs_t;

    typedef struct {
        logic rdv;
        logic wrr;
        obs_t exp;
    } vec_t;

    vec_t vec[$];
    int   total = 0;
    int   bad   = 0;
    logic cur_inv;

    task automatic check(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic drv(input int sel, input logic st, iv, ab, rv, wr, ds);
        if (sel == 0) begin
            st0 = st; iv0 = iv; ab0 = ab; rv0 = rv; wr0 = wr; ds0 = ds;
        end else begin
            st1 = st; iv1 = iv; ab1 = ab; rv1 = rv; wr1 = wr; ds1 = ds;
        end
    endtask

    task automatic smp(input int sel, output obs_t o);
        o = '0;
        if (sel == 0) begin
            o.am = am0; o.beat = 8'(beat0); o.grp = 8'(grp0); o.stg = 8'(stg0);
            o.re = re0; o.ie = ie0; o.le = le0; o.oe = oe0; o.we = we0; o.ss = ss0;
            o.busy = busy0; o.done = done0; o.inv = inv0; o.abt = abt0;
        end else begin
            o.am = am1; o.beat = 8'(beat1); o.grp = 8'(grp1); o.stg = 8'(stg1);
            o.re = re1; o.ie = ie1; o.le = le1; o.oe = oe1; o.we = we1; o.ss = ss1;
            o.busy = busy1; o.done = done1; o.inv = inv1; o.abt = abt1;
        end
    endtask

    function automatic obs_t base(input logic [1:0] am, input int b, g, s, input logic inv);
        obs_t o;
        o = '0;
        o.am = am; o.beat = 8'(b); o.grp = 8'(g); o.stg = 8'(s);
        o.busy = 1'b1; o.inv = inv;
        return o;
    endfunction

    function automatic logic junk(input int pct);
        return (pct > 0) ? 1'($urandom_range(1)) : 1'b1;
    endfunction

    // One handshake-gated beat: optional stall cycles, then the accepting cycle.
    task automatic push_hs(input logic [1:0] am, input int b, g, s, input logic inv,
                           input int pct, input int forced, input bit last);
        vec_t r;
        int   nst;
        bit   rd;
        rd  = (am != 2'b11);
        nst = forced;
        if (pct > 0) while ($urandom_range(99) < pct) nst++;
        for (int k = 0; k < nst; k++) begin
            r.exp    = base(am, b, g, s, inv);
            r.exp.re = rd;
            if (rd) begin r.rdv = 1'b0; r.wrr = junk(pct); end
            else    begin r.wrr = 1'b0; r.rdv = junk(pct); end
            vec.push_back(r);
        end
        r.exp    = base(am, b, g, s, inv);
        r.exp.re = rd;
        if (rd) begin
            r.rdv = 1'b1; r.wrr = junk(pct); r.exp.ie = 1'b1;
        end else begin
            r.wrr = 1'b1; r.rdv = junk(pct);
            r.exp.oe = 1'b1; r.exp.we = 1'b1; r.exp.ss = last;
        end
        vec.push_back(r);
    endtask

    // Expected cycle-by-cycle trace of a whole transform, from the nested phase structure.
    task automatic build(input int gs, tw, lat, groups, stages, input logic inv,
                         input int pct, input bit directed);
        vec_t r;
        vec.delete();
        for (int s = 0; s < stages; s++) begin
            for (int g = 0; g < groups; g++) begin
                for (int b = 0; b < gs; b++)
                    push_hs(2'b01, b, g, s, inv, pct, (directed && s == 0 && g == 0 && b == 10) ? 3 : 0, 1'b0);
                for (int b = 0; b < tw; b++)
                    push_hs(2'b10, b, g, s, inv, pct, 0, 1'b0);
                for (int b = 0; b < lat; b++) begin
                    r.exp = base(2'b00, b, g, s, inv);
                    r.rdv = junk(pct); r.wrr = junk(pct);
                    vec.push_back(r);
                end
                r.exp    = base(2'b00, 0, g, s, inv);
                r.exp.le = 1'b1;
                r.rdv = junk(pct); r.wrr = junk(pct);
                vec.push_back(r);
                for (int b = 0; b < gs; b++)
                    push_hs(2'b11, b, g, s, inv, pct,
                            (directed && s == 0 && g == 0 && b == gs - 1) ? 2 : 0,
                            (b == gs - 1) && (g == groups - 1));
            end
        end
        r.exp      = base(2'b00, 0, 0, stages - 1, inv);
        r.exp.done = 1'b1;
        r.rdv = junk(pct); r.wrr = junk(pct);
        vec.push_back(r);
    endtask

    task automatic run_vec(input int sel, input int spacing, input int exp_cycles, input int stages);
        obs_t o, e;
        int   last_ss = -1;
        int   nss     = 0;
        int   nbusy   = 0;
        @(posedge clk); #1;
        drv(sel, 1'b1, cur_inv, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < vec.size(); i++) begin
            drv(sel, 1'b0, ~cur_inv, 1'b0, vec[i].rdv, vec[i].wrr, 1'b0);
            #4;
            smp(sel, o);
            check($sformatf("vec[%0d]", i), o, vec[i].exp);
            if (o.busy && !o.done) nbusy++;
            if (o.ss) begin
                if (spacing > 0 && last_ss >= 0) check_int("stage_spacing", i - last_ss, spacing);
                last_ss = i;
                nss++;
            end
            @(posedge clk); #1;
        end
        check_int("busy_cycles", nbusy, exp_cycles);
        check_int("stage_strobes", nss, stages);
        drv(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #4;
        smp(sel, o);
        check_int("done_held", int'(o.done), 1);
        @(posedge clk); #1;
        drv(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        smp(sel, o);
        e = '0; e.inv = cur_inv;
        check("idle_after_sent", o, e);
    endtask

    task automatic wait_for(input logic [1:0] am, input int stg, input string name);
        obs_t o;
        bit   hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(posedge clk); #4;
            smp(0, o);
            if (o.am == am && (stg < 0 || int'(o.stg) == stg)) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s timeout got=none want=am%0d", name, am);
        end
    endtask

    initial begin
        obs_t o, e;
        n_rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        #13;
        smp(0, o); check("reset0", o, '0);
        smp(1, o); check("reset1", o, '0);
        #10 n_rst = 1'b1;

        // IDLE ignores abort/handshakes/data_sent; start wins over abort
        @(posedge clk); #1;
        drv(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #4;
        smp(0, o); check("idle_ignores", o, '0);
        #2 drv(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        smp(0, o);
        e = base(2'b01, 0, 0, 0, 1'b1); e.re = 1'b1;
        check("start_over_abort", o, e);
        #1 drv(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        smp(0, o);
        e = '0; e.inv = 1'b1; e.abt = 1'b1;
        check("abort_load_a", o, e);

        cur_inv = 1'b1;
        build(32, 16, 1, 2, 6, cur_inv, 0, 1'b0);
        run_vec(0, 164, 984, 6);

        cur_inv = 1'b0;
        build(32, 16, 1, 2, 6, cur_inv, 0, 1'b1);
        run_vec(0, 0, 984 + 5, 6);

        cur_inv = 1'($urandom_range(1));
        build(32, 16, 1, 2, 6, cur_inv, 25, 1'b0);
        run_vec(0, 0, vec.size() - 1, 6);

        // abort during LOAD_TW of stage 2
        @(posedge clk); #1;
        drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_for(2'b10, 2, "reach_stage2_tw");
        #1 drv(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        smp(0, o);
        e = '0; e.abt = 1'b1;
        check("abort_tw", o, e);
        @(posedge clk); #4;
        smp(0, o);
        check("abort_pulse_end", o, '0);
        cur_inv = 1'b1;
        build(32, 16, 1, 2, 6, cur_inv, 0, 1'b0);
        run_vec(0, 164, 984, 6);

        cur_inv = 1'b0;
        build(16, 4, 3, 1, 4, cur_inv, 0, 1'b0);
        run_vec(1, 40, 160, 4);

        // reset in the middle of SHIFT_OUT
        @(posedge clk); #1;
        drv(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_for(2'b11, -1, "reach_shift_out");
        n_rst = 1'b0;
        #1;
        smp(0, o); check("rst_mid_shift", o, '0);
        @(posedge clk); #4;
        smp(0, o); check("rst_held", o, '0);
        n_rst = 1'b1;
        drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #4;
        smp(0, o); check("rst_no_pulse", o, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
